// File: rtl/cmd_sender.sv
// -----------------------------------------------------------------------------
// cmd_sender
//
// Reads stored BLE AT-command strings from the command memory and streams
// them byte-by-byte into the UART TX FIFO that feeds the BLE module.
//
// Single-command mode (start) sends the command chosen by cmd_sel.
// Sequence mode (start_all) sends commands 0..count-1 in order.
// Sequence mode also inserts GAP_CYCLES idle cycles between commands.
//
// Memory layout:
//   address 0             : number of stored commands (count)
//   k*CMD_WIDTH+1 ..
//   k*CMD_WIDTH+CMD_WIDTH : command k, terminated by LF (0x0A)
//
// Ports:
//   clk, rst_n     system clock, asynchronous active-low reset
//   start          one-cycle request: send command cmd_sel
//   start_all      one-cycle request: send all stored commands
//                  (start_all wins if both are high in the same cycle)
//   cmd_sel        command index used by start
//   mem_rd_en      memory read strobe
//   mem_addr       memory byte address
//   mem_rdata      read data, valid one cycle after mem_rd_en
//   tx_full        TX FIFO full; no byte is written while it is high
//   tx_wr_en       TX FIFO write strobe, one cycle per byte
//   tx_data        byte written to the TX FIFO
//   busy           high whenever the FSM is not idle
//   done           one-cycle pulse on successful completion
//   error_code     0 none, 1 bad index, 2 no LF within the slot;
//                  holds its value until the next accepted start
//   error_pulse    one-cycle pulse, coincident with the error_code update
// -----------------------------------------------------------------------------
module cmd_sender #(
    parameter int CMD_WIDTH  = 32,
    parameter int CMD_DEPTH  = 16,
    parameter int GAP_CYCLES = 16
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start,
    input  logic                                  start_all,
    input  logic [$clog2(CMD_DEPTH)-1:0]          cmd_sel,
    output logic                                  mem_rd_en,
    output logic [$clog2(CMD_DEPTH*CMD_WIDTH)-1:0] mem_addr,
    input  logic [7:0]                            mem_rdata,
    input  logic                                  tx_full,
    output logic                                  tx_wr_en,
    output logic [7:0]                            tx_data,
    output logic                                  busy,
    output logic                                  done,
    output logic [2:0]                            error_code,
    output logic                                  error_pulse
);

    localparam int IDX_W  = $clog2(CMD_DEPTH);
    localparam int ADDR_W = $clog2(CMD_DEPTH * CMD_WIDTH);
    localparam int BYTE_W = $clog2(CMD_WIDTH);
    localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    // Highest usable slot: the last slot would run past the end of memory
    // because address 0 is taken by the count.
    localparam logic [7:0]        MAX_IDX   = 8'(CMD_DEPTH - 2);
    localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(CMD_WIDTH - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [7:0]        LF        = 8'h0A;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_IDX     = 3'd1;
    localparam logic [2:0] ERR_NO_TERM = 3'd2;

    typedef enum logic [3:0] {
        IDLE,
        RD_COUNT,
        WAIT_COUNT,
        CHECK,
        RD_BYTE,
        WAIT_BYTE,
        PUSH,
        END_CMD,
        GAP
    } state_t;

    state_t            state_reg,      state_next;
    logic              seq_mode_reg,   seq_mode_next;
    logic [7:0]        index_reg,      index_next;
    logic [BYTE_W-1:0] byte_idx_reg,   byte_idx_next;
    logic [7:0]        count_reg,      count_next;
    logic [7:0]        byte_reg,       byte_next;
    logic [GAP_W-1:0]  gap_cnt_reg,    gap_cnt_next;
    logic [2:0]        error_code_reg, error_code_next;
    logic              done_reg,       done_next;
    logic              error_pulse_reg, error_pulse_next;

    logic [7:0]        index_inc;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] byte_addr;

    assign index_inc = index_reg + 8'd1;

    // The slot base is formed at the full address width so k*CMD_WIDTH is
    // never truncated. Only in-range indices ever reach RD_BYTE, so the low
    // IDX_W bits of the index are the whole index there.
    assign base_addr = ADDR_W'(index_reg[IDX_W-1:0]) * ADDR_W'(CMD_WIDTH) + ADDR_W'(1);
    assign byte_addr = base_addr + ADDR_W'(byte_idx_reg);

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            seq_mode_reg    <= 1'b0;
            index_reg       <= '0;
            byte_idx_reg    <= '0;
            count_reg       <= '0;
            byte_reg        <= '0;
            gap_cnt_reg     <= '0;
            error_code_reg  <= ERR_NONE;
            done_reg        <= 1'b0;
            error_pulse_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            seq_mode_reg    <= seq_mode_next;
            index_reg       <= index_next;
            byte_idx_reg    <= byte_idx_next;
            count_reg       <= count_next;
            byte_reg        <= byte_next;
            gap_cnt_reg     <= gap_cnt_next;
            error_code_reg  <= error_code_next;
            done_reg        <= done_next;
            error_pulse_reg <= error_pulse_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next       = state_reg;
        seq_mode_next    = seq_mode_reg;
        index_next       = index_reg;
        byte_idx_next    = byte_idx_reg;
        count_next       = count_reg;
        byte_next        = byte_reg;
        gap_cnt_next     = gap_cnt_reg;
        error_code_next  = error_code_reg;
        done_next        = 1'b0;
        error_pulse_next = 1'b0;
        mem_rd_en        = 1'b0;
        mem_addr         = '0;
        tx_wr_en         = 1'b0;

        unique case (state_reg)
            IDLE: begin
                // start_all has priority simply because it selects the mode.
                if (start || start_all) begin
                    seq_mode_next   = start_all;
                    index_next      = start_all ? 8'd0 : 8'(cmd_sel);
                    byte_idx_next   = '0;
                    error_code_next = ERR_NONE;
                    state_next      = RD_COUNT;
                end
            end

            RD_COUNT: begin
                mem_rd_en  = 1'b1;
                mem_addr   = '0;
                state_next = WAIT_COUNT;
            end

            WAIT_COUNT: begin
                count_next = mem_rdata;
                state_next = CHECK;
            end

            CHECK: begin
                if (seq_mode_reg && (count_reg == 8'd0)) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end else if ((index_reg >= count_reg) || (index_reg > MAX_IDX)) begin
                    error_code_next  = ERR_IDX;
                    error_pulse_next = 1'b1;
                    state_next       = IDLE;
                end else begin
                    state_next = RD_BYTE;
                end
            end

            RD_BYTE: begin
                mem_rd_en  = 1'b1;
                mem_addr   = byte_addr;
                state_next = WAIT_BYTE;
            end

            WAIT_BYTE: begin
                byte_next  = mem_rdata;
                state_next = PUSH;
            end

            PUSH: begin
                // tx_full is looked at only here, so a FIFO that fills while
                // the byte is being fetched simply stretches this state.
                if (!tx_full) begin
                    tx_wr_en = 1'b1;
                    if (byte_reg == LF) begin
                        state_next = END_CMD;
                    end else if (byte_idx_reg == LAST_BYTE) begin
                        error_code_next  = ERR_NO_TERM;
                        error_pulse_next = 1'b1;
                        state_next       = IDLE;
                    end else begin
                        byte_idx_next = byte_idx_reg + BYTE_W'(1);
                        state_next    = RD_BYTE;
                    end
                end
            end

            END_CMD: begin
                if (!seq_mode_reg) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end else begin
                    index_next    = index_inc;
                    byte_idx_next = '0;
                    if (index_inc == count_reg) begin
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end else if (index_inc > MAX_IDX) begin
                        // A count larger than the number of usable slots would
                        // otherwise walk the address off the end of memory;
                        // the gap path does not revisit CHECK.
                        error_code_next  = ERR_IDX;
                        error_pulse_next = 1'b1;
                        state_next       = IDLE;
                    end else begin
                        gap_cnt_next = '0;
                        state_next   = GAP;
                    end
                end
            end

            GAP: begin
                if (gap_cnt_reg == GAP_LAST) begin
                    state_next = RD_BYTE;
                end else begin
                    gap_cnt_next = gap_cnt_reg + GAP_W'(1);
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign tx_data     = byte_reg;
    assign busy        = (state_reg != IDLE);
    assign done        = done_reg;
    assign error_code  = error_code_reg;
    assign error_pulse = error_pulse_reg;

endmodule

// File: tb/tb_cmd_sender.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_cmd_sender
//
// Scoreboard bench for cmd_sender. A behavioural memory with a registered
// read port holds the command strings; for every request the bench walks its
// own copy of the memory, queues the bytes it expects on the TX FIFO port and
// pops/compares them as tx_wr_en pulses arrive.
// -----------------------------------------------------------------------------
module tb_cmd_sender;

    localparam int CMD_WIDTH  = 32;
    localparam int CMD_DEPTH  = 16;
    localparam int GAP_CYCLES = 16;
    localparam int MEM_SIZE   = CMD_WIDTH * CMD_DEPTH;
    localparam int IDX_W      = $clog2(CMD_DEPTH);
    localparam int ADDR_W     = $clog2(MEM_SIZE);
    localparam int RUN_LIMIT  = 3000;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              start_all = 1'b0;
    logic [IDX_W-1:0]  cmd_sel = '0;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata;
    logic              tx_full = 1'b0;
    logic              tx_wr_en;
    logic [7:0]        tx_data;
    logic              busy;
    logic              done;
    logic [2:0]        error_code;
    logic              error_pulse;

    logic [7:0] mem [0:MEM_SIZE-1];
    logic [7:0] exp_q [$];

    int checks   = 0;
    int failures = 0;

    cmd_sender #(
        .CMD_WIDTH  (CMD_WIDTH),
        .CMD_DEPTH  (CMD_DEPTH),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .start_all   (start_all),
        .cmd_sel     (cmd_sel),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .tx_full     (tx_full),
        .tx_wr_en    (tx_wr_en),
        .tx_data     (tx_data),
        .busy        (busy),
        .done        (done),
        .error_code  (error_code),
        .error_pulse (error_pulse)
    );

    always #5 clk = ~clk;

    // Command memory: data appears one cycle after the read strobe.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic put_cmd(input int k, input string s);
        for (int i = 0; i < s.len(); i++) mem[k*CMD_WIDTH + 1 + i] = s[i];
    endtask

    task automatic load_default();
        for (int i = 0; i < MEM_SIZE; i++) mem[i] = 8'h00;
        mem[0] = 8'd7;
        put_cmd(0, "AT\r\n");
        put_cmd(1, "AT+NAME?\r\n");
        put_cmd(2, "AT+PIN123456\r\n");
        put_cmd(3, "AT+BAUD4   \r\n");
        put_cmd(4, "AT+ROLE0\r\n");
        put_cmd(5, "AT+VERSION\r\n");
        put_cmd(6, "AT+RESET\r\n");
    endtask

    // Queue the bytes of slot k up to and including the first LF.
    task automatic expect_cmd(input int k, output bit has_lf);
        has_lf = 1'b0;
        for (int i = 0; i < CMD_WIDTH && !has_lf; i++) begin
            logic [7:0] b;
            b = mem[k*CMD_WIDTH + 1 + i];
            exp_q.push_back(b);
            if (b == 8'h0A) has_lf = 1'b1;
        end
    endtask

    // One request: build expectations, pulse the start input(s), then watch
    // every cycle until the DUT has been idle for a few cycles.
    //   stall_byte >= 0 : hold tx_full for 20 cycles once that many bytes went out
    //   poke            : pulse start/start_all again while the DUT is busy
    task automatic run_cmd(input string name, input bit one, input bit all,
                           input int sel, input int stall_byte, input bit poke);
        int cnt, exp_err, exp_done, n_exp, t;
        int wr_n, done_n, errp_n, first_wr_t, last_wr_t, first_rd, stall_left, idle_n;
        bit has_lf, prev_lf;
        logic [7:0] exp_b;

        exp_q.delete();
        cnt     = int'(mem[0]);
        exp_err = 0;
        if (all) begin
            for (int k = 0; k < cnt && exp_err == 0; k++) begin
                if (k > CMD_DEPTH - 2) exp_err = 1;
                else begin
                    expect_cmd(k, has_lf);
                    if (!has_lf) exp_err = 2;
                end
            end
        end else begin
            if (sel >= cnt || sel > CMD_DEPTH - 2) exp_err = 1;
            else begin
                expect_cmd(sel, has_lf);
                if (!has_lf) exp_err = 2;
            end
        end
        exp_done = (exp_err == 0) ? 1 : 0;
        n_exp    = exp_q.size();

        wr_n = 0; done_n = 0; errp_n = 0; first_wr_t = -1; last_wr_t = 0;
        first_rd = -1; stall_left = 20; idle_n = 0; prev_lf = 1'b0;

        @(negedge clk);
        start = one; start_all = all; cmd_sel = IDX_W'(sel);
        @(negedge clk);
        start = 1'b0; start_all = 1'b0;

        // t = 0 is the first cycle after the request was sampled.
        t = 0;
        while (idle_n < 3 && t < RUN_LIMIT) begin
            if (stall_byte >= 0 && wr_n == stall_byte && stall_left > 0) begin
                tx_full = 1'b1;
                stall_left--;
            end else begin
                tx_full = 1'b0;
            end
            if (poke && t == 8) begin
                start = 1'b1; start_all = 1'b1; cmd_sel = IDX_W'(sel + 1);
            end else begin
                start = 1'b0; start_all = 1'b0;
            end
            #1;
            if (mem_rd_en && mem_addr != '0 && first_rd < 0) first_rd = int'(mem_addr);
            if (done) done_n++;
            if (error_pulse) begin
                errp_n++;
                check({name, "/code_at_pulse"}, 32'(error_code), exp_err);
            end
            if (tx_full) check({name, "/wr_while_full"}, 32'(tx_wr_en), 0);
            if (tx_wr_en) begin
                check({name, "/wr_pending"}, (exp_q.size() > 0) ? 1 : 0, 1);
                if (exp_q.size() > 0) begin
                    exp_b = exp_q.pop_front();
                    check({name, "/tx_data"}, 32'(tx_data), 32'(exp_b));
                end
                if (first_wr_t < 0) first_wr_t = t;
                if (prev_lf) check({name, "/gap"}, ((t - last_wr_t - 1) >= GAP_CYCLES) ? 1 : 0, 1);
                prev_lf   = (tx_data == 8'h0A);
                last_wr_t = t;
                wr_n++;
            end
            if (!busy) idle_n++;
            @(negedge clk);
            t++;
        end
        tx_full = 1'b0;
        start   = 1'b0;
        start_all = 1'b0;

        check({name, "/idle_at_end"}, 32'(busy), 0);
        check({name, "/writes"}, wr_n, n_exp);
        check({name, "/q_empty"}, exp_q.size(), 0);
        check({name, "/done"}, done_n, exp_done);
        check({name, "/err_pulse"}, errp_n, (exp_err != 0) ? 1 : 0);
        check({name, "/err_code"}, 32'(error_code), exp_err);
        if (n_exp > 0) check({name, "/first_wr_latency"}, first_wr_t, 5);
        if (one && !all && exp_err != 1) check({name, "/first_rd_addr"}, first_rd, sel*CMD_WIDTH + 1);
        $display("run %s: writes=%0d done=%0d error_pulses=%0d error_code=%0d cycles=%0d",
                 name, wr_n, done_n, errp_n, error_code, t);
    endtask

    initial begin
        int n, d;

        load_default();

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst/busy", 32'(busy), 0);
        check("rst/done", 32'(done), 0);
        check("rst/tx_wr_en", 32'(tx_wr_en), 0);
        check("rst/mem_rd_en", 32'(mem_rd_en), 0);
        check("rst/mem_addr", 32'(mem_addr), 0);
        check("rst/error_code", 32'(error_code), 0);
        check("rst/error_pulse", 32'(error_pulse), 0);
        rst_n = 1'b1;

        run_cmd("seq_default", 1'b0, 1'b1, 0, -1, 1'b0);
        run_cmd("single_2",    1'b1, 1'b0, 2, -1, 1'b0);
        run_cmd("stall_b3",    1'b1, 1'b0, 2,  3, 1'b0);
        run_cmd("bad_idx_9",   1'b1, 1'b0, 9, -1, 1'b0);
        mem[0] = 8'd15;
        run_cmd("bad_idx_15",  1'b1, 1'b0, 15, -1, 1'b0);

        load_default();
        for (int i = 0; i < CMD_WIDTH; i++) mem[1 + i] = 8'h41;
        run_cmd("no_term",     1'b1, 1'b0, 0, -1, 1'b0);

        // Reset in the middle of a command
        load_default();
        @(negedge clk);
        start = 1'b1; cmd_sel = IDX_W'(2);
        @(negedge clk);
        start = 1'b0;
        n = 0;
        for (int i = 0; i < 100 && n < 4; i++) begin
            #1;
            if (tx_wr_en) n++;
            @(negedge clk);
        end
        check("rst_mid/reached_byte4", n, 4);
        rst_n = 1'b0;
        #1;
        check("rst_mid/busy", 32'(busy), 0);
        check("rst_mid/tx_wr_en", 32'(tx_wr_en), 0);
        check("rst_mid/mem_rd_en", 32'(mem_rd_en), 0);
        check("rst_mid/mem_addr", 32'(mem_addr), 0);
        check("rst_mid/tx_data", 32'(tx_data), 0);
        check("rst_mid/done", 32'(done), 0);
        check("rst_mid/error_code", 32'(error_code), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0; d = 0;
        repeat (30) begin
            @(negedge clk);
            #1;
            if (tx_wr_en) n++;
            if (done) d++;
        end
        check("rst_mid/writes_after", n, 0);
        check("rst_mid/done_after", d, 0);
        check("rst_mid/busy_after", 32'(busy), 0);
        $display("run rst_mid: reset asserted after 4 writes");

        run_cmd("after_rst",   1'b1, 1'b0, 0, -1, 1'b0);
        run_cmd("busy_poke",   1'b1, 1'b0, 3, -1, 1'b1);
        mem[0] = 8'd0;
        run_cmd("both_cnt0",   1'b1, 1'b1, 2, -1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
